row_builder_param: RTL
======================

// Module: row_builder_param
// PURPOSE
//   Parametrised nonogram row builder: takes a clue list (block lengths plus extra gap cells) and
//   emits a packed 2-bit-per-cell row with the blocks placed left- or right-justified.
//   Adds a valid/ready handshake, a clue count up to MAX_CLUES and an overflow flag.
//   Sits between the puzzle loader and the line solver, which uses the two justified placements
//   to find overlap cells.
// PARAMETERS
//   ROW_LEN    10  cells per row (>=1)
//   MAX_CLUES  5   max blocks per row (>=1)
//   CLUE_W     4   bits per clue / gap value
//   ACC_W      localparam = $clog2(2*MAX_CLUES*(2**CLUE_W)+1); sum width, never wraps
// PORTS
//   clk_in        in   1                        system clock
//   reset_in      in   1                        synchronous, active-high reset
//   in_valid      in   1                        clue set present
//   in_ready      out  1                        block idle; accepts when in_valid&in_ready
//   clues         in   MAX_CLUES*CLUE_W         clue k at [k*CLUE_W +: CLUE_W], k=0 leftmost
//   gaps          in   MAX_CLUES*CLUE_W         extra empty cells after clue k, beyond 1 separator
//   num_clues     in   $clog2(MAX_CLUES+1)      number of valid clues
//   right_align   in   1                        0: start at cell 0; 1: last block ends at ROW_LEN-1
//   row_out       out  2*ROW_LEN                cell c at [2c+:2]; FILLED=2'b01, EMPTY=2'b10
//   out_valid     out  1                        row_out/min_length/overflow valid; held until out_ready
//   out_ready     in   1                        consumer takes result
//   min_length    out  ACC_W                    sum(clues)+(num_clues-1)+sum(gaps[0..n-2])
//   overflow      out  1                        min_length>ROW_LEN or num_clues>MAX_CLUES
// BEHAVIOUR
//   - Reset: state IDLE, row_out all EMPTY (2'b10 per cell), out_valid=0, min_length=0,
//     overflow=0. in_ready=0 while reset_in=1; in_ready=1 from the first cycle after reset drops.
//     Reset mid-operation aborts and discards the in-progress row.
//   - in_ready = (state==IDLE). Inputs are sampled on the accepting edge only.
//     Later changes to the inputs have no effect.
//   - FSM: IDLE -> SUM (MAX_CLUES cycles; cycle k adds clue k and, if k<num_clues-1, 1+gaps[k];
//     records start_k/end_k) -> FILL (ROW_LEN cycles, cell c per cycle) -> DONE.
//     DONE -> IDLE on out_ready.
//   - SUM only includes clues k<num_clues. gaps of the last clue and of unused slots are ignored.
//   - After SUM, if overflow: skip FILL, go straight to DONE with row_out all EMPTY.
//   - FILL: offset = right_align ? ROW_LEN-min_length : 0. Cell c is FILLED iff
//     start_k+offset <= c < end_k+offset for some valid k, else EMPTY.
//   - Latency: out_valid rises exactly 1+MAX_CLUES+ROW_LEN cycles after the accept edge
//     (1+MAX_CLUES on overflow).
//   - out_valid stays high and all outputs are stable until the cycle with out_ready=1.
//     The next cycle is IDLE: out_valid=0, outputs hold their last values.
//   - num_clues=0: row all EMPTY, min_length=0, overflow=0, normal latency.
//   - A clue value of 0 contributes no filled cells but still contributes its separator.
// STRUCTURE
//   - nonogram_pkg: CELL_FILLED/CELL_EMPTY constants, cell_t typedef, rb_state_t enum.
//   - Sub-module clue_span_calc: serial accumulator producing start_k/end_k, min_length, overflow.
//     The top level holds the FSM, the fill loop and the handshake.
// TESTING  (ROW_LEN=10, MAX_CLUES=5, CLUE_W=4)
//   - clues{3,2}, gaps{0}, n=2, left -> cells 0-2,4-5 FILLED, rest EMPTY; min_length=6;
//     out_valid 16 cycles after accept.
//   - Same clues, right_align=1 -> cells 4-6,8-9 FILLED, 0-3,7 EMPTY; min_length=6, overflow=0.
//   - clues{5,5}, gaps{1}, n=2 -> min_length=12, overflow=1, row all EMPTY;
//     out_valid 6 cycles after accept.
//   - n=0 -> row all EMPTY, min_length=0, overflow=0; n=6 -> overflow=1.
//   - out_ready low 20 cycles after done -> outputs stable, in_ready=0, in_valid pulses ignored;
//     out_ready=1 -> IDLE next cycle.
//   - reset_in pulsed mid-FILL -> next cycle out_valid=0, row all EMPTY, in_ready=1;
//     a fresh request then completes normally.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared cell encoding and FSM state type for the nonogram row builder.
package nonogram_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_FILLED = 2'b01;
  localparam cell_t CELL_EMPTY  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_FILL,
    ST_DONE
  } rb_state_t;

endpackage

// File: rtl/clue_span_calc.sv
// Serial clue accumulator: one clue per step, records block start/end cells,
// running minimum row length and the overflow condition.
module clue_span_calc #(
  parameter int unsigned ROW_LEN   = 10,
  parameter int unsigned MAX_CLUES = 5,
  parameter int unsigned CLUE_W    = 4,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned NW        = 3
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic                              clear,
  input  logic                              step,
  input  logic [NW-1:0]                     k_idx,
  input  logic [NW-1:0]                     num_clues,
  input  logic [CLUE_W-1:0]                 clue,
  input  logic [CLUE_W-1:0]                 gap,
  output logic [MAX_CLUES-1:0][ACC_W-1:0]   starts,
  output logic [MAX_CLUES-1:0][ACC_W-1:0]   ends,
  output logic [ACC_W-1:0]                  min_length,
  output logic                              overflow,
  output logic [ACC_W-1:0]                  min_length_c,
  output logic                              overflow_c
);

  logic [ACC_W-1:0]                acc_q, acc_d;
  logic                            ovf_q, ovf_d;
  logic [MAX_CLUES-1:0][ACC_W-1:0] starts_q, starts_d;
  logic [MAX_CLUES-1:0][ACC_W-1:0] ends_q, ends_d;
  logic                            in_use;
  logic                            has_next;

  // A clue adds its length; a separator plus extra gap only if another clue follows.
  always_comb begin
    acc_d    = acc_q;
    starts_d = starts_q;
    ends_d   = ends_q;
    in_use   = (k_idx < num_clues) && (32'(k_idx) < MAX_CLUES);
    has_next = ((NW+1)'(k_idx) + (NW+1)'(1)) < (NW+1)'(num_clues);
    if (clear) begin
      acc_d    = '0;
      starts_d = '0;
      ends_d   = '0;
    end else if (step && in_use) begin
      starts_d[k_idx] = acc_q;
      ends_d[k_idx]   = acc_q + ACC_W'(clue);
      acc_d           = acc_q + ACC_W'(clue) +
                        (has_next ? (ACC_W'(1) + ACC_W'(gap)) : ACC_W'(0));
    end
    ovf_d = (32'(acc_d) > ROW_LEN) || (32'(num_clues) > MAX_CLUES);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      starts_q <= '0;
      ends_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      starts_q <= starts_d;
      ends_q   <= ends_d;
    end
  end

  assign starts       = starts_q;
  assign ends         = ends_q;
  assign min_length   = acc_q;
  assign overflow     = ovf_q;
  assign min_length_c = acc_d;
  assign overflow_c   = ovf_d;

endmodule

// File: rtl/row_builder_param.sv
// Nonogram row builder: latches a clue set, sums spans serially, then paints
// one cell per cycle with blocks left- or right-justified.
module row_builder_param
  import nonogram_pkg::*;
#(
  parameter  int unsigned ROW_LEN   = 10,
  parameter  int unsigned MAX_CLUES = 5,
  parameter  int unsigned CLUE_W    = 4,
  localparam int unsigned ACC_W     = $clog2(2*MAX_CLUES*(2**CLUE_W)+1),
  localparam int unsigned NW        = $clog2(MAX_CLUES+1)
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CLUES*CLUE_W-1:0]   clues,
  input  logic [MAX_CLUES*CLUE_W-1:0]   gaps,
  input  logic [NW-1:0]                 num_clues,
  input  logic                          right_align,
  output logic [2*ROW_LEN-1:0]          row_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              min_length,
  output logic                          overflow
);

  localparam int unsigned CW = $clog2(ROW_LEN+1);
  localparam logic [2*ROW_LEN-1:0] ALL_EMPTY = {ROW_LEN{CELL_EMPTY}};

  rb_state_t                     state_q, state_d;
  logic [NW-1:0]                 k_q, k_d;
  logic [CW-1:0]                 c_q, c_d;
  logic [MAX_CLUES*CLUE_W-1:0]   clues_q, clues_d;
  logic [MAX_CLUES*CLUE_W-1:0]   gaps_q, gaps_d;
  logic [NW-1:0]                 num_q, num_d;
  logic                          ralign_q, ralign_d;
  cell_t [ROW_LEN-1:0]           work_q, work_d;
  cell_t [ROW_LEN-1:0]           row_q, row_d;
  logic                          out_valid_q, out_valid_d;
  logic [ACC_W-1:0]              min_len_q, min_len_d;
  logic                          ovf_q, ovf_d;

  logic                          span_clear;
  logic                          span_step;
  logic [CLUE_W-1:0]             clue_k;
  logic [CLUE_W-1:0]             gap_k;
  logic [MAX_CLUES-1:0][ACC_W-1:0] span_starts;
  logic [MAX_CLUES-1:0][ACC_W-1:0] span_ends;
  logic [ACC_W-1:0]              span_min;
  logic                          span_ovf;
  logic [ACC_W-1:0]              span_min_c;
  logic                          span_ovf_c;
  logic [31:0]                   offset;
  logic                          accept;

  // True when cell c lies inside any valid block shifted by off.
  function automatic logic cell_hit(
    input logic [MAX_CLUES-1:0][ACC_W-1:0] st,
    input logic [MAX_CLUES-1:0][ACC_W-1:0] en,
    input logic [NW-1:0]                   n,
    input logic [31:0]                     off,
    input logic [31:0]                     c
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < MAX_CLUES; k++) begin
      if ((k < 32'(n)) && ((32'(st[k]) + off) <= c) && (c < (32'(en[k]) + off)))
        hit = 1'b1;
    end
    return hit;
  endfunction

  assign in_ready = (state_q == ST_IDLE) && !reset_in;
  assign accept   = in_valid && in_ready;
  assign clue_k   = clues_q[32'(k_q)*CLUE_W +: CLUE_W];
  assign gap_k    = gaps_q[32'(k_q)*CLUE_W +: CLUE_W];
  assign offset   = ralign_q ? (ROW_LEN - 32'(span_min)) : 32'd0;

  clue_span_calc #(
    .ROW_LEN   (ROW_LEN),
    .MAX_CLUES (MAX_CLUES),
    .CLUE_W    (CLUE_W),
    .ACC_W     (ACC_W),
    .NW        (NW)
  ) u_span (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .clear        (span_clear),
    .step         (span_step),
    .k_idx        (k_q),
    .num_clues    (num_q),
    .clue         (clue_k),
    .gap          (gap_k),
    .starts       (span_starts),
    .ends         (span_ends),
    .min_length   (span_min),
    .overflow     (span_ovf),
    .min_length_c (span_min_c),
    .overflow_c   (span_ovf_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    c_d         = c_q;
    clues_d     = clues_q;
    gaps_d      = gaps_q;
    num_d       = num_q;
    ralign_d    = ralign_q;
    work_d      = work_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    min_len_d   = min_len_q;
    ovf_d       = ovf_q;
    span_clear  = 1'b0;
    span_step   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          clues_d    = clues;
          gaps_d     = gaps;
          num_d      = num_clues;
          ralign_d   = right_align;
          k_d        = '0;
          span_clear = 1'b1;
          state_d    = ST_SUM;
        end
      end
      ST_SUM: begin
        span_step = 1'b1;
        k_d       = k_q + NW'(1);
        if (32'(k_q) == MAX_CLUES - 1) begin
          k_d = '0;
          if (span_ovf_c) begin
            row_d     = ALL_EMPTY;
            min_len_d = span_min_c;
            ovf_d     = 1'b1;
            state_d   = ST_DONE;
          end else begin
            c_d     = '0;
            work_d  = ALL_EMPTY;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        work_d[c_q] = cell_hit(span_starts, span_ends, num_q, offset, 32'(c_q))
                      ? CELL_FILLED : CELL_EMPTY;
        c_d = c_q + CW'(1);
        if (32'(c_q) == ROW_LEN - 1) begin
          row_d     = work_d;
          min_len_d = span_min;
          ovf_d     = span_ovf;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // out_valid rises one cycle after entry; release only once it has been seen.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      c_q         <= '0;
      clues_q     <= '0;
      gaps_q      <= '0;
      num_q       <= '0;
      ralign_q    <= 1'b0;
      work_q      <= ALL_EMPTY;
      row_q       <= ALL_EMPTY;
      out_valid_q <= 1'b0;
      min_len_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      clues_q     <= clues_d;
      gaps_q      <= gaps_d;
      num_q       <= num_d;
      ralign_q    <= ralign_d;
      work_q      <= work_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      min_len_q   <= min_len_d;
      ovf_q       <= ovf_d;
    end
  end

  assign row_out    = row_q;
  assign out_valid  = out_valid_q;
  assign min_length = min_len_q;
  assign overflow   = ovf_q;

endmodule
